// File: rtl/dac_event_sequencer_pkg.sv
// Shared types for the DAC event sequencer: command opcodes, the 128-bit timed entry and DDS word widths.
package dac_seq_pkg;

  localparam int FREQ_W  = 48;
  localparam int AMP_W   = 14;
  localparam int TS_W    = 64;
  localparam int CHF_W   = 14;
  localparam int ENTRY_W = 128;

  typedef enum logic [1:0] {
    OP_FREQ  = 2'b00,
    OP_AMPPH = 2'b01,
    OP_AOFS  = 2'b10,
    OP_MODE  = 2'b11
  } op_e;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    op_e               op;
    logic [CHF_W-1:0]  ch;
    logic [FREQ_W-1:0] payload;
  } entry_t;

endpackage

// File: rtl/dac_event_sequencer_if.sv
// Command push port of the sequencer: write/flush strobes, entry data and buffer status.
interface dac_event_sequencer_if #(
  parameter int LVL_W = 7
);
  logic             flush;
  logic             write;
  logic [127:0]     fifo_din;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] fill_level;

  modport master (output flush, write, fifo_din, input full, empty, fill_level);
  modport slave  (input flush, write, fifo_din, output full, empty, fill_level);
endinterface

// File: rtl/dac_event_sequencer_fifo.sv
// Show-ahead synchronous command FIFO; head always presents the oldest entry, flush overrides push and pop.
module dac_seq_fifo
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  entry_t           i_din,
  output entry_t           o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = LVL_W - 1;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic             r_empty;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_push;
  logic             w_pop;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  always_comb begin
    w_pop       = i_pop && !r_empty && !i_flush;
    w_push      = i_push && !i_flush && (!r_full || w_pop);
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_W'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      r_empty <= (w_level_nxt == LVL_W'(0));
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/dac_event_sequencer.sv
// Timed-event sequencer: releases buffered commands when the global counter reaches their timestamp
// and applies them to per-channel DDS registers, with sticky error capture.
module dac_event_sequencer
  import dac_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  dac_event_sequencer_if.slave     bus,
  input  logic                     auto_start,
  input  logic [63:0]              counter,
  output logic [NUM_CH*FREQ_W-1:0] ch_freq,
  output logic [NUM_CH*AMP_W-1:0]  ch_amp,
  output logic [NUM_CH*AMP_W-1:0]  ch_phase,
  output logic [NUM_CH*AMP_W-1:0]  ch_amp_offset,
  output logic [NUM_CH-1:0]        ch_mode,
  output logic [NUM_CH-1:0]        ch_update,
  output logic                     timestamp_error,
  output logic                     overflow_error,
  output logic                     chan_error,
  output logic [127:0]             error_data,
  input  logic                     error_clear
);

  entry_t             w_head;
  entry_t             w_din;
  logic               w_full;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic               w_eval;
  logic               w_ts_eq;
  logic               w_ts_lt;
  logic               w_pop;
  logic               w_ch_ok;
  logic               w_disp_ok;
  logic               w_ts_err;
  logic               w_ch_err;
  logic               w_ovf;
  logic [CH_W-1:0]    w_ch_idx;
  logic               w_any_flag;
  entry_t             w_err_entry;

  logic [FREQ_W-1:0]  r_freq  [NUM_CH];
  logic [AMP_W-1:0]   r_amp   [NUM_CH];
  logic [AMP_W-1:0]   r_phase [NUM_CH];
  logic [AMP_W-1:0]   r_aofs  [NUM_CH];
  logic [NUM_CH-1:0]  r_mode;
  logic [NUM_CH-1:0]  r_update;
  logic               r_ts_err;
  logic               r_ovf_err;
  logic               r_ch_err;
  entry_t             r_err_data;

  assign w_din = entry_t'(bus.fifo_din);

  dac_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .i_flush (bus.flush),
    .i_push  (bus.write),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.fill_level = w_level;

  // Head classification: on time dispatches, late entries are discarded as errors, early ones wait.
  always_comb begin
    w_eval      = auto_start && !w_empty && !bus.flush;
    w_ts_eq     = (w_head.ts == counter);
    w_ts_lt     = (w_head.ts < counter);
    w_pop       = w_eval && (w_ts_eq || w_ts_lt);
    w_ch_ok     = (w_head.ch < CHF_W'(NUM_CH));
    w_disp_ok   = w_eval && w_ts_eq && w_ch_ok;
    w_ch_err    = w_eval && w_ts_eq && !w_ch_ok;
    w_ts_err    = w_eval && w_ts_lt;
    w_ovf       = bus.write && w_full && !w_pop && !bus.flush;
    w_ch_idx    = w_head.ch[CH_W-1:0];
    w_any_flag  = r_ts_err || r_ovf_err || r_ch_err;
    if (w_ts_err || w_ch_err) begin
      w_err_entry = w_head;
    end else begin
      w_err_entry = w_din;
    end
  end

  // Per-channel DDS register file with a single-cycle update strobe per write.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_freq[i]  <= '0;
        r_amp[i]   <= '0;
        r_phase[i] <= '0;
        r_aofs[i]  <= '0;
      end
      r_mode   <= '0;
      r_update <= '0;
    end else begin
      r_update <= '0;
      if (w_disp_ok) begin
        r_update[w_ch_idx] <= 1'b1;
        case (w_head.op)
          OP_FREQ:  r_freq[w_ch_idx] <= w_head.payload[47:0];
          OP_AMPPH: begin
            r_amp[w_ch_idx]   <= w_head.payload[27:14];
            r_phase[w_ch_idx] <= w_head.payload[13:0];
          end
          OP_AOFS:  r_aofs[w_ch_idx] <= w_head.payload[13:0];
          OP_MODE:  r_mode[w_ch_idx] <= w_head.payload[0];
          default:  r_mode <= r_mode;
        endcase
      end
    end
  end

  // Sticky error flags; error_data holds the first offender, a simultaneous new error beats a clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_ts_err   <= 1'b0;
      r_ovf_err  <= 1'b0;
      r_ch_err   <= 1'b0;
      r_err_data <= '0;
    end else begin
      if (error_clear) begin
        r_ts_err  <= w_ts_err;
        r_ovf_err <= w_ovf;
        r_ch_err  <= w_ch_err;
      end else begin
        r_ts_err  <= r_ts_err  | w_ts_err;
        r_ovf_err <= r_ovf_err | w_ovf;
        r_ch_err  <= r_ch_err  | w_ch_err;
      end
      if ((w_ts_err || w_ch_err || w_ovf) && (!w_any_flag || error_clear)) begin
        r_err_data <= w_err_entry;
      end else if (error_clear) begin
        r_err_data <= '0;
      end else begin
        r_err_data <= r_err_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign ch_freq[g*FREQ_W +: FREQ_W]      = r_freq[g];
    assign ch_amp[g*AMP_W +: AMP_W]         = r_amp[g];
    assign ch_phase[g*AMP_W +: AMP_W]       = r_phase[g];
    assign ch_amp_offset[g*AMP_W +: AMP_W]  = r_aofs[g];
  end

  assign ch_mode         = r_mode;
  assign ch_update       = r_update;
  assign timestamp_error = r_ts_err;
  assign overflow_error  = r_ovf_err;
  assign chan_error      = r_ch_err;
  assign error_data      = r_err_data;

endmodule

// File: tb/tb_dac_event_sequencer.sv
// Directed self-checking bench for dac_event_sequencer (NUM_CH=4, FIFO_DEPTH=64).
module tb_dac_event_sequencer;

  logic         clk;
  logic         rst_n;
  logic         auto_start;
  logic [63:0]  counter;
  logic [191:0] ch_freq;
  logic [55:0]  ch_amp;
  logic [55:0]  ch_phase;
  logic [55:0]  ch_amp_offset;
  logic [3:0]   ch_mode;
  logic [3:0]   ch_update;
  logic         timestamp_error;
  logic         overflow_error;
  logic         chan_error;
  logic [127:0] error_data;
  logic         error_clear;

  int checks;
  int failures;
  int pulses;

  logic [127:0] e_a;
  logic [127:0] e_b;
  logic [127:0] e_ovf;

  dac_event_sequencer_if #(.LVL_W(7)) bus ();

  dac_event_sequencer #(.NUM_CH(4), .FIFO_DEPTH(64)) dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .bus             (bus),
    .auto_start      (auto_start),
    .counter         (counter),
    .ch_freq         (ch_freq),
    .ch_amp          (ch_amp),
    .ch_phase        (ch_phase),
    .ch_amp_offset   (ch_amp_offset),
    .ch_mode         (ch_mode),
    .ch_update       (ch_update),
    .timestamp_error (timestamp_error),
    .overflow_error  (overflow_error),
    .chan_error      (chan_error),
    .error_data      (error_data),
    .error_clear     (error_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [63:0] ts, input logic [1:0] op,
                                      input logic [13:0] ch, input logic [47:0] pl);
    return {ts, op, ch, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] e);
    bus.write    = 1'b1;
    bus.fifo_din = e;
    tick();
    bus.write    = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; pulses = 0;
    rst_n = 1'b0; auto_start = 1'b0; counter = 64'd0; error_clear = 1'b0;
    bus.write = 1'b0; bus.flush = 1'b0; bus.fifo_din = 128'd0;
    tick(); tick();
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_level", bus.fill_level, 7'd0);
    chk("rst_freq", ch_freq, 192'd0);
    chk("rst_flags", {timestamp_error, overflow_error, chan_error, ch_update, ch_mode}, 11'd0);
    chk("rst_edata", error_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // Three timed frequency writes to channel 1.
    push(mk(64'd100, 2'b00, 14'd1, 48'h1111_2222_3333));
    push(mk(64'd200, 2'b00, 14'd1, 48'h4444_5555_6666));
    push(mk(64'd300, 2'b00, 14'd1, 48'h7777_8888_9999));
    chk("lvl3", bus.fill_level, 7'd3);
    auto_start = 1'b1;
    for (int c = 0; c <= 400; c++) begin
      counter = 64'(c);
      tick();
      if (ch_update[1]) pulses++;
      if (c == 99)  chk("freq_before100", ch_freq[48 +: 48], 48'h0);
      if (c == 100) chk("freq_at100", {ch_update, ch_freq[48 +: 48]}, {4'b0010, 48'h1111_2222_3333});
      if (c == 101) chk("upd_after100", ch_update, 4'b0000);
      if (c == 200) chk("freq_at200", ch_freq[48 +: 48], 48'h4444_5555_6666);
      if (c == 299) chk("freq_hold299", ch_freq[48 +: 48], 48'h4444_5555_6666);
      if (c == 300) chk("freq_at300", ch_freq[48 +: 48], 48'h7777_8888_9999);
    end
    chk("pulses", 128'(pulses), 128'd3);
    chk("empty_end", bus.empty, 1'b1);
    chk("no_ts_err", timestamp_error, 1'b0);

    // Stale entry.
    counter = 64'd80;
    e_a = mk(64'd50, 2'b00, 14'd0, 48'hAAAA_0000_0001);
    push(e_a);
    tick();
    chk("stale_flag", timestamp_error, 1'b1);
    chk("stale_data", error_data, e_a);
    chk("stale_noupd", {bus.empty, ch_update, ch_freq[0 +: 48]}, {1'b1, 4'b0000, 48'h0});
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("clr_flag", timestamp_error, 1'b0);
    chk("clr_data", error_data, 128'd0);

    // Fill to capacity, then overflow.
    auto_start = 1'b0;
    push(mk(64'd1000, 2'b00, 14'd3, 48'hABCD_0000_0003));
    for (int i = 1; i < 64; i++) push(mk(64'hF000_0000_0000_0000 | 64'(i), 2'b00, 14'd3, 48'(i)));
    chk("full_flag", {bus.full, bus.fill_level}, {1'b1, 7'd64});
    e_ovf = mk(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 14'd3, 48'hDEAD);
    push(e_ovf);
    chk("ovf_flag", overflow_error, 1'b1);
    chk("ovf_data", error_data, e_ovf);
    chk("ovf_level", bus.fill_level, 7'd64);
    counter = 64'd1000;
    auto_start = 1'b1;
    push(mk(64'hF000_0000_0000_1000, 2'b00, 14'd3, 48'h5555));
    auto_start = 1'b0;
    chk("wrpop_level", {bus.full, bus.fill_level}, {1'b1, 7'd64});
    chk("wrpop_disp", {ch_update, ch_freq[144 +: 48]}, {4'b1000, 48'hABCD_0000_0003});
    chk("ovf_keep", {overflow_error, error_data}, {1'b1, e_ovf});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_empty", {bus.empty, bus.fill_level}, {1'b1, 7'd0});
    chk("flush_keep", ch_freq[144 +: 48], 48'hABCD_0000_0003);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("ovf_clr", overflow_error, 1'b0);

    // Amplitude/phase, amp offset and mode opcodes.
    counter = 64'd2000;
    auto_start = 1'b1;
    push(mk(64'd2000, 2'b01, 14'd2, {20'h0, 14'h1FFF, 14'h0ABC}));
    tick();
    chk("ampph_upd", ch_update, 4'b0100);
    chk("amp2", ch_amp[28 +: 14], 14'h1FFF);
    chk("phase2", ch_phase[28 +: 14], 14'h0ABC);
    chk("amp_others", {ch_amp[0 +: 28], ch_amp[42 +: 14], ch_phase[0 +: 28], ch_phase[42 +: 14]}, 84'd0);
    push(mk(64'd2000, 2'b10, 14'd1, 48'h0000_0000_0123));
    tick();
    chk("aofs1", ch_amp_offset, {14'h0, 14'h0, 14'h0123, 14'h0});
    push(mk(64'd2000, 2'b11, 14'd0, 48'h1));
    tick();
    chk("mode0", {ch_update, ch_mode}, {4'b0001, 4'b0001});

    // Bad channel, then clear coinciding with a new error.
    e_b = mk(64'd2000, 2'b00, 14'd7, 48'h7777);
    push(e_b);
    tick();
    chk("chan_err", {chan_error, ch_update, bus.empty}, {1'b1, 4'b0000, 1'b1});
    chk("chan_data", error_data, e_b);
    e_a = mk(64'd10, 2'b00, 14'd0, 48'h0BAD);
    push(e_a);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("clr_vs_new", {timestamp_error, chan_error}, 2'b10);
    chk("clr_vs_new_data", error_data, e_a);

    // Dispatch disabled with a matching timestamp.
    auto_start = 1'b0;
    push(mk(64'd2000, 2'b00, 14'd1, 48'hC0DE));
    tick(); tick();
    chk("hold_noauto", {bus.empty, bus.fill_level, ch_update}, {1'b0, 7'd1, 4'b0000});
    auto_start = 1'b1;
    tick();
    chk("resume", {bus.empty, ch_freq[48 +: 48]}, {1'b1, 48'hC0DE});

    // Asynchronous reset mid-stream, then flush colliding with write.
    auto_start = 1'b0;
    push(mk(64'd5000, 2'b00, 14'd2, 48'h1));
    push(mk(64'd5001, 2'b00, 14'd2, 48'h2));
    rst_n = 1'b0;
    #1;
    chk("arst_regs", {ch_freq, ch_mode, ch_update}, 200'd0);
    chk("arst_buf", {bus.empty, bus.full, bus.fill_level, timestamp_error, error_data}, {1'b1, 1'b0, 7'd0, 1'b0, 128'd0});
    tick();
    rst_n = 1'b1;
    tick();
    bus.flush = 1'b1;
    push(mk(64'd6000, 2'b00, 14'd0, 48'h3));
    bus.flush = 1'b0;
    chk("flush_wr", {bus.empty, bus.fill_level, overflow_error}, {1'b1, 7'd0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
